// File: rtl/nonce_reporter_if.sv
// Bus between the core array / host readback logic and nonce_reporter.
// The master side drives nonce strobes, flush and the readback ready.
// The slave side (the reporter) returns the report stream and drop counter.
interface nonce_reporter_if #(
    parameter int NUM_CORES = 4
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                      flush;
    logic [NUM_CORES-1:0]      found_valid;
    logic [32*NUM_CORES-1:0]   found_nonce;
    logic                      out_valid;
    logic                      out_ready;
    logic [43:0]               out_data;
    logic [CW-1:0]             out_core;
    logic [7:0]                dropped;

    modport master (
        output flush, found_valid, found_nonce, out_ready,
        input  out_valid, out_data, out_core, dropped
    );

    modport slave (
        input  flush, found_valid, found_nonce, out_ready,
        output out_valid, out_data, out_core, dropped
    );
endinterface

// File: rtl/nonce_reporter.sv
// Golden-nonce reporter: per-core capture registers, round-robin arbiter,
// one-entry stage that feeds a CRC12 generator, and a small report FIFO
// that the host drains. The CRC lets the host repair readback bit-flips.

// CRC12 over a 32-bit nonce, polynomial x^12 + POLY. The nonce is shifted
// in starting from bit 0, so bit 0 carries the highest-order coefficient.
module crc12 #(
    parameter logic [11:0] POLY = 12'h3F9
) (
    input  logic [31:0] i_data,
    output logic [11:0] o_crc
);
    logic [11:0] w_acc;

    // Bit-serial Galois division unrolled over the 32 nonce bits.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (w_acc[11]) begin
                w_acc = {w_acc[10:0], i_data[i]} ^ POLY;
            end else begin
                w_acc = {w_acc[10:0], i_data[i]};
            end
        end
    end

    assign o_crc = w_acc;
endmodule

module nonce_reporter #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    nonce_reporter_if.slave   bus
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // capture registers
    logic [NUM_CORES-1:0] r_pend_v;
    logic [31:0]          r_pend_nonce [NUM_CORES];

    // arbiter
    logic [CW-1:0]        r_rr;
    logic [CW-1:0]        w_cand;
    logic                 w_grant_en;
    logic                 w_grant;
    logic [CW-1:0]        w_grant_idx;
    logic [CW-1:0]        w_rr_next;
    logic [NUM_CORES-1:0] w_gnt_vec;
    int                   w_drop_sum;
    int                   w_drop_total;

    // stage
    logic                 r_stage_v;
    logic [CW-1:0]        r_stage_core;
    logic [31:0]          r_stage_nonce;
    logic [11:0]          w_crc;

    // report FIFO
    logic [43:0]          r_fifo_data [FIFO_DEPTH];
    logic [CW-1:0]        r_fifo_core [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [43:0]          r_last_data;
    logic [CW-1:0]        r_last_core;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_ne;

    logic [7:0]           r_dropped;

    crc12 #(.POLY(12'h3F9)) u_crc12 (
        .i_data (r_stage_nonce),
        .o_crc  (w_crc)
    );

    // Round-robin pick among pending cores. A FIFO slot is reserved at grant
    // time (stage counts as occupied), so the stage never pushes into a full
    // FIFO. No grant during flush: everything in flight is being discarded.
    always_comb begin
        w_grant_en  = (int'(r_count) + int'(r_stage_v)) < FIFO_DEPTH;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_cand = CW'((int'(r_rr) + k) % NUM_CORES);
            if (!w_grant && w_grant_en && !bus.flush && r_pend_v[w_cand]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        w_rr_next = (int'(w_grant_idx) == NUM_CORES - 1) ? '0 : w_grant_idx + 1'b1;
    end

    // Per-core grant decode and count of nonces lost this cycle. A strobe on
    // a core that is being granted (or flushed) replaces its slot, so no loss.
    always_comb begin
        w_gnt_vec  = '0;
        w_drop_sum = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_gnt_vec[i] = w_grant && (w_grant_idx == CW'(i));
            if (bus.found_valid[i] && r_pend_v[i] && !w_gnt_vec[i] && !bus.flush) begin
                w_drop_sum = w_drop_sum + 1;
            end
        end
        w_drop_total = int'(r_dropped) + w_drop_sum;
    end

    // Capture per-core nonces; pending clears on grant or flush unless refilled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_v <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_pend_nonce[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus.found_valid[i] && (!r_pend_v[i] || w_gnt_vec[i] || bus.flush)) begin
                    r_pend_v[i]     <= 1'b1;
                    r_pend_nonce[i] <= bus.found_nonce[32*i +: 32];
                end else if (w_gnt_vec[i] || bus.flush) begin
                    r_pend_v[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating drop counter; survives flush.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dropped <= '0;
        end else if (w_drop_total > 255) begin
            r_dropped <= 8'hFF;
        end else begin
            r_dropped <= 8'(w_drop_total);
        end
    end

    // Round-robin pointer advances past the granted core only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr <= '0;
        end else if (w_grant) begin
            r_rr <= w_rr_next;
        end
    end

    // Stage register: holds the granted nonce for one cycle while its CRC settles.
    always_ff @(posedge i_clk) begin
        if (i_reset || bus.flush) begin
            r_stage_v     <= 1'b0;
            r_stage_core  <= '0;
            r_stage_nonce <= '0;
        end else begin
            r_stage_v <= w_grant;
            if (w_grant) begin
                r_stage_core  <= w_grant_idx;
                r_stage_nonce <= r_pend_nonce[w_grant_idx];
            end
        end
    end

    assign w_fifo_ne = (r_count != '0);
    assign w_push    = r_stage_v && !bus.flush;
    assign w_pop     = w_fifo_ne && bus.out_ready && !bus.flush;

    // FIFO storage; contents are only meaningful below r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= {r_stage_nonce, w_crc};
            r_fifo_core[r_wr_ptr] <= r_stage_core;
        end
    end

    // FIFO pointers, occupancy and the hold value shown while empty.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_data <= '0;
            r_last_core <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            if (w_fifo_ne) begin
                r_last_data <= r_fifo_data[r_rd_ptr];
                r_last_core <= r_fifo_core[r_rd_ptr];
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_last_data <= r_fifo_data[r_rd_ptr];
                r_last_core <= r_fifo_core[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_valid = w_fifo_ne;
    assign bus.out_data  = w_fifo_ne ? r_fifo_data[r_rd_ptr] : r_last_data;
    assign bus.out_core  = w_fifo_ne ? r_fifo_core[r_rd_ptr] : r_last_core;
    assign bus.dropped   = r_dropped;
endmodule
